// File: rtl/codificador_pt2262.sv
// PT2262-style remote-control encoder: serialises A0..A7 (0/1/F) and D0..D3 then a sync symbol.
// Latency: cod_o and busy go high on the same clk edge that samples te=1 in IDLE.
// Backpressure: none; te is a level request, and each frame always runs to completion.
module codificador_pt2262 #(
  parameter int ALPHA_DIV  = 250,
  parameter int MIN_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       te,
  input  logic [7:0] addr_val,
  input  logic [7:0] addr_flt,
  input  logic [3:0] d,
  output logic       cod_o,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [15:0] DIV_M1   = 16'(ALPHA_DIV - 1);
  localparam logic [3:0]  MIN_FRMS = 4'(MIN_FRAMES);

  typedef enum logic [1:0] {IDLE, SYMBOL, SYNC} state_t;

  state_t      state;
  logic [3:0]  sym_idx;
  logic [6:0]  alpha_cnt;
  logic [15:0] presc;
  logic [3:0]  frame_cnt;
  logic [7:0]  lat_val;
  logic [7:0]  lat_flt;
  logic [3:0]  lat_d;

  // Next position in the waveform; outputs are registered from this so they line up with it.
  state_t      n_state;
  logic [3:0]  n_idx;
  logic [6:0]  n_alpha;
  logic [15:0] n_presc;
  logic        relatch;
  logic        start_tx;
  logic        frame_end;
  logic [3:0]  cnt_inc;
  logic        tick;
  logic        n_flt;
  logic        n_val;
  logic        n_long;
  logic        n_level;
  logic        n_fd;

  assign tick    = (presc == DIV_M1);
  assign cnt_inc = (frame_cnt == 4'd15) ? 4'd15 : frame_cnt + 4'd1;

  // Advance prescaler / alpha / symbol position and choose the next state.
  always_comb begin
    n_state   = state;
    n_idx     = sym_idx;
    n_alpha   = alpha_cnt;
    n_presc   = presc;
    relatch   = 1'b0;
    start_tx  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        n_presc = 16'd0;
        if (te) begin
          n_state  = SYMBOL;
          n_idx    = 4'd0;
          n_alpha  = 7'd0;
          relatch  = 1'b1;
          start_tx = 1'b1;
        end
      end
      SYMBOL: begin
        if (tick) begin
          n_presc = 16'd0;
          if (alpha_cnt == 7'd31) begin
            n_alpha = 7'd0;
            if (sym_idx == 4'd11) begin
              n_state = SYNC;
              n_idx   = 4'd0;
            end else begin
              n_idx = sym_idx + 4'd1;
            end
          end else begin
            n_alpha = alpha_cnt + 7'd1;
          end
        end else begin
          n_presc = presc + 16'd1;
        end
      end
      SYNC: begin
        if (tick) begin
          n_presc = 16'd0;
          if (alpha_cnt == 7'd127) begin
            frame_end = 1'b1;
            n_alpha   = 7'd0;
            n_idx     = 4'd0;
            // Decision uses the post-increment count so MIN_FRAMES whole frames go out.
            if (te || (cnt_inc < MIN_FRMS)) begin
              n_state = SYMBOL;
              relatch = 1'b1;
            end else begin
              n_state = IDLE;
            end
          end else begin
            n_alpha = alpha_cnt + 7'd1;
          end
        end else begin
          n_presc = presc + 16'd1;
        end
      end
      default: begin
        n_state = IDLE;
        n_idx   = 4'd0;
        n_alpha = 7'd0;
        n_presc = 16'd0;
      end
    endcase
  end

  // Waveform level at the next position. Alpha 0 is high for every symbol, so using the
  // old latched inputs on a relatch edge is harmless.
  always_comb begin
    n_flt = 1'b0;
    n_val = 1'b0;
    if (n_idx < 4'd8) begin
      n_flt = lat_flt[n_idx[2:0]];
      n_val = lat_val[n_idx[2:0]];
    end else begin
      n_val = lat_d[n_idx[1:0]];
    end
    // F is short then long; float overrides the value bit.
    n_long  = n_flt ? n_alpha[4] : n_val;
    n_level = 1'b0;
    case (n_state)
      SYMBOL:  n_level = n_long ? (n_alpha[3:0] < 4'd12) : (n_alpha[3:0] < 4'd4);
      SYNC:    n_level = (n_alpha < 7'd4);
      default: n_level = 1'b0;
    endcase
    n_fd = (n_state == SYNC) && (n_alpha == 7'd127) && (n_presc == DIV_M1);
  end

  // State, counters, input latches and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sym_idx    <= 4'd0;
      alpha_cnt  <= 7'd0;
      presc      <= 16'd0;
      frame_cnt  <= 4'd0;
      lat_val    <= 8'd0;
      lat_flt    <= 8'd0;
      lat_d      <= 4'd0;
      cod_o      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= n_state;
      sym_idx    <= n_idx;
      alpha_cnt  <= n_alpha;
      presc      <= n_presc;
      cod_o      <= n_level;
      busy       <= (n_state != IDLE);
      frame_done <= n_fd;
      if (start_tx) begin
        frame_cnt <= 4'd0;
      end else if (frame_end) begin
        frame_cnt <= cnt_inc;
      end
      if (relatch) begin
        lat_val <= addr_val;
        lat_flt <= addr_flt;
        lat_d   <= d;
      end
    end
  end

endmodule
